// File: rtl/axi4_frame_mem_slave.sv
// rtl/axi4_frame_mem_slave.sv - AXI4 slave terminating frame-buffer write/read masters on block RAM
module axi4_frame_mem_slave #(
  parameter int                DATA_W      = 64,
  parameter int                DEPTH_WORDS = 38400,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000
) (
  input  logic                  clk_100Mhz,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic                  s_wlast,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  s_rlast,
  output logic [3:0]            err_flags
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // A burst is usable only if it lies wholly inside the store and uses 8-byte beats.
  function automatic logic burst_ok(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] word,
                                    input logic [7:0] len, input logic [2:0] size);
    logic [ADDR_W:0] end_excl;
    end_excl = {1'b0, word} + (ADDR_W+1)'(len) + (ADDR_W+1)'(1);
    return (addr >= BASE_ADDR) && (end_excl <= (ADDR_W+1)'(DEPTH_WORDS)) && (size == 3'b011);
  endfunction

  logic [ADDR_W-1:0] aw_word, ar_word;
  assign aw_word = (s_awaddr - BASE_ADDR) >> 3;
  assign ar_word = (s_araddr - BASE_ADDR) >> 3;

  logic unused_burst;
  assign unused_burst = ^{s_awburst, s_arburst};

  w_state_t          w_state_q, w_state_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic              w_ok_q, w_ok_d;
  logic [2:0]        w_err_q, w_err_d;
  logic              w_beat;

  r_state_t          r_state_q, r_state_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [8:0]        r_iss_q, r_iss_d;
  logic              r_ok_q, r_ok_d;
  logic              r_err_q, r_err_d;
  logic              r_issue;

  logic              rd_v_q, rd_last_q, skid_v_q, skid_last_q;
  logic [DATA_W-1:0] rd_data_q, skid_data_q;

  // Write channel next-state and handshake outputs.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_ok_d    = w_ok_q;
    w_err_d   = w_err_q;
    w_beat    = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    case (w_state_q)
      W_IDLE: begin
        s_awready = ~rst;
        if (s_awvalid) begin
          w_idx_d   = aw_word[IDX_W-1:0];
          w_len_d   = s_awlen;
          w_cnt_d   = 8'd0;
          w_ok_d    = burst_ok(s_awaddr, aw_word, s_awlen, s_awsize);
          if (!w_ok_d) w_err_d[2] = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          w_beat  = 1'b1;
          w_idx_d = w_idx_q + IDX_W'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          if (s_wlast || (w_cnt_q == w_len_q)) begin
            if (s_wlast && (w_cnt_q != w_len_q)) w_err_d[0] = 1'b1;
            if (!s_wlast) w_err_d[1] = 1'b1;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = w_ok_q ? 2'b00 : 2'b10;
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: issue one memory read per cycle while the skid slot is free.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_iss_d   = r_iss_q;
    r_ok_d    = r_ok_q;
    r_err_d   = r_err_q;
    r_issue   = 1'b0;
    s_arready = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_arready = ~rst;
        if (s_arvalid) begin
          r_idx_d   = ar_word[IDX_W-1:0];
          r_len_d   = s_arlen;
          r_iss_d   = 9'd0;
          r_ok_d    = burst_ok(s_araddr, ar_word, s_arlen, s_arsize);
          if (!r_ok_d) r_err_d = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (!skid_v_q && (r_iss_q <= {1'b0, r_len_q})) begin
          r_issue = 1'b1;
          r_idx_d = r_idx_q + IDX_W'(1);
          r_iss_d = r_iss_q + 9'd1;
        end
        if (s_rvalid && s_rready && s_rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Skid ordering: the skid entry, when valid, is always older than the read register.
  assign s_rvalid  = skid_v_q | rd_v_q;
  assign s_rlast   = skid_v_q ? skid_last_q : (rd_v_q & rd_last_q);
  assign s_rdata   = skid_v_q ? skid_data_q : (rd_v_q ? rd_data_q : '0);
  assign s_rresp   = (s_rvalid && !r_ok_q) ? 2'b10 : 2'b00;
  assign err_flags = {r_err_q, w_err_q};

  // Control state, with asynchronous abort of both channels.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      w_ok_q      <= 1'b0;
      w_err_q     <= '0;
      r_state_q   <= R_IDLE;
      r_idx_q     <= '0;
      r_len_q     <= '0;
      r_iss_q     <= '0;
      r_ok_q      <= 1'b0;
      r_err_q     <= 1'b0;
      rd_v_q      <= 1'b0;
      rd_last_q   <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_last_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_ok_q    <= w_ok_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_iss_q   <= r_iss_d;
      r_ok_q    <= r_ok_d;
      r_err_q   <= r_err_d;
      if (r_issue) begin
        rd_v_q    <= 1'b1;
        rd_last_q <= (r_iss_q == {1'b0, r_len_q});
        if (rd_v_q && !s_rready) begin
          skid_v_q    <= 1'b1;
          skid_last_q <= rd_last_q;
        end
      end else if (skid_v_q) begin
        if (s_rready) skid_v_q <= 1'b0;
      end else if (rd_v_q && s_rready) begin
        rd_v_q <= 1'b0;
      end
    end
  end

  // Block RAM: byte-masked write port, read-first synchronous read port.
  always_ff @(posedge clk_100Mhz) begin
    if (w_beat && w_ok_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
    if (r_issue) begin
      if (rd_v_q && !skid_v_q && !s_rready) skid_data_q <= rd_data_q;
      rd_data_q <= r_ok_q ? mem[r_idx_q] : '0;
    end
  end

endmodule

// File: tb/tb_axi4_frame_mem_slave.sv
// tb/tb_axi4_frame_mem_slave.sv - directed self-checking bench for axi4_frame_mem_slave
module tb_axi4_frame_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_arvalid, s_arready;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst;
  logic [63:0] s_wdata, s_rdata;
  logic [7:0]  s_wstrb;
  logic        s_wvalid, s_wready, s_wlast;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready;
  logic        s_rvalid, s_rready, s_rlast;
  logic [3:0]  err_flags;

  int checks = 0;
  int errors = 0;

  logic [63:0] wbuf [256];
  logic [63:0] rbuf [256];
  logic [1:0]  rrsp [256];
  int nbeats, first_lat, last_err, unstable;

  always #5 clk = ~clk;

  axi4_frame_mem_slave dut (
    .clk_100Mhz(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast),
    .err_flags(err_flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aw_hs(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    @(negedge clk);
    s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = 2'b01; s_awvalid = 1'b1;
    #1;
    while (!s_awready && n < 50) begin @(negedge clk); #1; n++; end
    check("aw_accept", 64'(s_awready), 64'd1);
    @(negedge clk);
    s_awvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] strb,
                             input int last_at, output int beats, output logic [1:0] resp);
    int n = 0;
    aw_hs(addr, len, 3'b011);
    beats = 0;
    s_wstrb = strb;
    for (int k = 0; k < 300; k++) begin
      s_wvalid = 1'b1; s_wdata = wbuf[beats[7:0]]; s_wlast = (beats == last_at);
      #1;
      if (!s_wready) break;
      @(negedge clk);
      beats++;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    check("bvalid_timing", 64'(s_bvalid), 64'd1);
    while (s_bvalid !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    resp = s_bresp;
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    #1;
    check("b_done", 64'(s_bvalid), 64'd0);
    check("aw_ready_after_b", 64'(s_awready), 64'd1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
    int k, n;
    bit held, done;
    logic [63:0] prev_d;
    logic prev_l;
    nbeats = 0; first_lat = 0; last_err = 0; unstable = 0; held = 0; done = 0; n = 0;
    prev_d = '0; prev_l = 1'b0;
    @(negedge clk);
    s_araddr = addr; s_arlen = len; s_arsize = 3'b011; s_arburst = 2'b01; s_arvalid = 1'b1;
    s_rready = 1'b0;
    #1;
    while (!s_arready && n < 50) begin @(negedge clk); #1; n++; end
    check("ar_accept", 64'(s_arready), 64'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
    k = 1;
    while (!done && k < 2000) begin
      s_rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (held && (s_rvalid !== 1'b1 || s_rdata !== prev_d || s_rlast !== prev_l)) unstable++;
      held = 0;
      if (s_rvalid === 1'b1) begin
        if (first_lat == 0) first_lat = k;
        if (s_rready) begin
          if (nbeats < 256) begin
            rbuf[nbeats] = s_rdata;
            rrsp[nbeats] = s_rresp;
          end
          if (s_rlast !== (nbeats == int'(len))) last_err++;
          nbeats++;
          done = (s_rlast === 1'b1);
        end else begin
          held = 1; prev_d = s_rdata; prev_l = s_rlast;
        end
      end
      @(negedge clk);
      k++;
    end
    s_rready = 1'b0;
    check("r_done", 64'(done), 64'd1);
    #1;
    check("ar_ready_after_r", 64'(s_arready), 64'd1);
    check("rvalid_after_r", 64'(s_rvalid), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, bad;
    logic [1:0] resp;
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_wlast = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_rready = 0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_awready", 64'(s_awready), 0);
    check("rst_wready", 64'(s_wready), 0);
    check("rst_bvalid", 64'(s_bvalid), 0);
    check("rst_arready", 64'(s_arready), 0);
    check("rst_rvalid", 64'(s_rvalid), 0);
    check("rst_rlast", 64'(s_rlast), 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_err", 64'(err_flags), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_awready", 64'(s_awready), 1);
    check("idle_arready", 64'(s_arready), 1);

    // 16-beat write then read back
    for (int i = 0; i < 16; i++) wbuf[i] = 64'(i);
    write_burst(32'h1000_0000, 8'd15, 8'hFF, 15, beats, resp);
    check("t1_wbeats", 64'(beats), 16);
    check("t1_bresp", 64'(resp), 0);
    read_burst(32'h1000_0000, 8'd15, 1'b0);
    check("t1_rbeats", 64'(nbeats), 16);
    check("t1_first_lat", 64'(first_lat), 2);
    check("t1_rlast", 64'(last_err), 0);
    check("t1_rresp", 64'(rrsp[0]), 0);
    for (int i = 0; i < 16; i++) check($sformatf("t1_rdata%0d", i), rbuf[i], 64'(i));

    // byte strobes
    wbuf[0] = 64'h1111_2222_3333_4444;
    write_burst(32'h1000_0008, 8'd0, 8'hFF, 0, beats, resp);
    wbuf[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    write_burst(32'h1000_0008, 8'd0, 8'h0F, 0, beats, resp);
    check("t2_bresp", 64'(resp), 0);
    read_burst(32'h1000_0008, 8'd0, 1'b0);
    check("t2_rbeats", 64'(nbeats), 1);
    check("t2_rdata", rbuf[0], 64'h1111_2222_CCCC_DDDD);
    check("t2_rlast", 64'(last_err), 0);
    check("t2_err", 64'(err_flags), 0);

    // 256-beat read with rready back-pressure
    for (int i = 0; i < 256; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    write_burst(32'h1000_0320, 8'd255, 8'hFF, 255, beats, resp);
    check("t3_wbeats", 64'(beats), 256);
    read_burst(32'h1000_0320, 8'd255, 1'b1);
    check("t3_rbeats", 64'(nbeats), 256);
    check("t3_stable", 64'(unstable), 0);
    check("t3_rlast", 64'(last_err), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (rbuf[i] !== (64'hC0DE_0000_0000_0000 | 64'(i))) bad++;
    check("t3_data_mismatches", 64'(bad), 0);

    // top-of-store boundary and out-of-range bursts
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h7777_0000_0000_0000 + 64'(i);
    write_burst(32'h1004_AFE0, 8'd3, 8'hFF, 3, beats, resp);
    check("t4_edge_bresp", 64'(resp), 0);
    check("t4_edge_err", 64'(err_flags), 0);
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hDEAD_0000_0000_0000 + 64'(i);
    write_burst(32'h1004_AFE0, 8'd7, 8'hFF, 7, beats, resp);
    check("t4_oor_wbeats", 64'(beats), 8);
    check("t4_oor_bresp", 64'(resp), 2);
    check("t4_oor_werr", 64'(err_flags), 4'b0100);
    read_burst(32'h1004_AFE0, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_unchanged%0d", i), rbuf[i], 64'h7777_0000_0000_0000 + 64'(i));
    read_burst(32'h1004_AFE0, 8'd7, 1'b0);
    check("t4_oor_rbeats", 64'(nbeats), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_oor_rresp%0d", i), 64'(rrsp[i]), 2);
      check($sformatf("t4_oor_rdata%0d", i), rbuf[i], 0);
    end
    check("t4_oor_rerr", 64'(err_flags), 4'b1100);

    // WLAST protocol errors
    write_burst(32'h1000_0000, 8'd3, 8'hFF, 1, beats, resp);
    check("t5_early_beats", 64'(beats), 2);
    check("t5_early_bresp", 64'(resp), 0);
    check("t5_early_err", 64'(err_flags), 4'b1101);
    write_burst(32'h1000_0000, 8'd3, 8'hFF, -1, beats, resp);
    check("t5_missing_beats", 64'(beats), 4);
    check("t5_missing_err", 64'(err_flags), 4'b1111);

    // overlapped write to A and read from B
    for (int i = 0; i < 64; i++) wbuf[i] = 64'hB0B0_0000_0000_0000 + 64'(i);
    write_burst(32'h1002_7100, 8'd63, 8'hFF, 63, beats, resp);
    for (int i = 0; i < 64; i++) wbuf[i] = 64'hA0A0_0000_0000_0000 + 64'(i);
    fork
      write_burst(32'h1000_1F40, 8'd63, 8'hFF, 63, beats, resp);
      read_burst(32'h1002_7100, 8'd63, 1'b1);
    join
    check("t6_wbeats", 64'(beats), 64);
    check("t6_bresp", 64'(resp), 0);
    check("t6_rbeats", 64'(nbeats), 64);
    check("t6_stable", 64'(unstable), 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (rbuf[i] !== 64'hB0B0_0000_0000_0000 + 64'(i)) bad++;
    check("t6_b_mismatches", 64'(bad), 0);
    read_burst(32'h1000_1F40, 8'd63, 1'b0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (rbuf[i] !== 64'hA0A0_0000_0000_0000 + 64'(i)) bad++;
    check("t6_a_mismatches", 64'(bad), 0);

    // reset in the middle of both bursts
    for (int i = 0; i < 16; i++) wbuf[i] = 64'h5000 + 64'(i);
    aw_hs(32'h1000_0640, 8'd15, 3'b011);
    s_wstrb = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      s_wvalid = 1'b1; s_wdata = wbuf[i]; s_wlast = 1'b0;
      @(negedge clk);
    end
    s_wvalid = 1'b0;
    #1;
    check("t7_in_wburst", 64'(s_wready), 1);
    s_araddr = 32'h1000_0000; s_arlen = 8'd7; s_arsize = 3'b011; s_arvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk);
    s_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t7_in_rburst", 64'(s_rvalid), 1);
    rst = 1'b1;
    #1;
    check("t7_awready", 64'(s_awready), 0);
    check("t7_wready", 64'(s_wready), 0);
    check("t7_bvalid", 64'(s_bvalid), 0);
    check("t7_arready", 64'(s_arready), 0);
    check("t7_rvalid", 64'(s_rvalid), 0);
    check("t7_rlast", 64'(s_rlast), 0);
    check("t7_rdata", s_rdata, 0);
    check("t7_resp", 64'({s_bresp, s_rresp}), 0);
    check("t7_err", 64'(err_flags), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t7_idle_awready", 64'(s_awready), 1);
    check("t7_idle_arready", 64'(s_arready), 1);
    wbuf[0] = 64'hFEED;
    write_burst(32'h1000_0668, 8'd0, 8'hFF, 0, beats, resp);
    check("t7_bresp", 64'(resp), 0);
    read_burst(32'h1000_0640, 8'd5, 1'b0);
    check("t7_rbeats", 64'(nbeats), 6);
    for (int i = 0; i < 5; i++) check($sformatf("t7_partial%0d", i), rbuf[i], 64'h5000 + 64'(i));
    check("t7_after", rbuf[5], 64'hFEED);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_frame_mem_slave.md
Name: axi4_frame_mem_slave

Overview:
AXI4 slave responder that terminates the 64-bit AXI4 write master (camera-to-frame-buffer path) and the 64-bit AXI4 read master (frame-buffer-to-HDMI path) on an on-chip block-RAM frame store. It substitutes for the Zynq HP0/HP1 + DDR path in simulation and in PL-only builds. Write and read channels are independent and run concurrently on one 100 MHz clock.

Parameters:
DATA_W, 64, data bus width in bits; fixed at 64, with 8 strobe bits.
DEPTH_WORDS, 38400, number of 64-bit words in memory (320x240x16 bpp = 153600 bytes = 19200 words, double buffered).
BASE_ADDR, 32'h1000_0000, byte address mapped to word 0.
ADDR_W, 32, AXI address width.

Ports:
clk_100Mhz  in  1  AXI clock.
rst  in  1  asynchronous reset, active-high.
s_awaddr  in  32  write burst start byte address.
s_awvalid  in  1  write address valid.
s_awready  out  1  write address ready.
s_awlen  in  8  beats minus 1.
s_awsize  in  3  must be 3'b011; other values are flagged as an error.
s_awburst  in  2  burst type; always treated as INCR.
s_wdata  in  64  write data.
s_wstrb  in  8  byte enables.
s_wvalid  in  1  write data valid.
s_wready  out  1  write data ready.
s_wlast  in  1  last write beat.
s_bresp  out  2  write response.
s_bvalid  out  1  write response valid.
s_bready  in  1  write response ready.
s_araddr  in  32  read burst start byte address.
s_arvalid  in  1  read address valid.
s_arready  out  1  read address ready.
s_arlen  in  8  beats minus 1.
s_arsize  in  3  must be 3'b011.
s_arburst  in  2  burst type; always treated as INCR.
s_rdata  out  64  read data.
s_rresp  out  2  read response.
s_rvalid  out  1  read data valid.
s_rready  in  1  read data ready.
s_rlast  out  1  last read beat.
err_flags  out  4  sticky error flags: [0] early WLAST, [1] missing WLAST, [2] write out-of-range or bad size, [3] read out-of-range or bad size.

Behaviour:
- Reset: all outputs are 0. Write FSM and read FSM go to IDLE. Memory contents are not cleared. err_flags clears only on rst.
- Address decode: word index = (addr - BASE_ADDR) >> 3; the low 3 address bits are ignored. A burst is in range iff BASE_ADDR <= addr and index + len + 1 <= DEPTH_WORDS. There is no wrap-around.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: s_awready = 1. On s_awvalid & s_awready, latch index, len and ok (in range and awsize == 3); go to W_DATA on the next cycle. s_awready drops.
  - W_DATA: s_wready = 1. Each s_wvalid & s_wready beat writes the bytes of mem[index] selected by wstrb, provided ok = 1; otherwise the beat is discarded. Then index increments and the 8-bit beat counter increments.
  - Burst termination: the burst ends on the beat where counter == len. If s_wlast = 1 earlier, set err_flags[0] and still end on that WLAST beat. If counter == len and s_wlast = 0, set err_flags[1] and end anyway.
  - W_RESP: s_bvalid = 1, with s_bresp = 2'b00 if ok, else 2'b10 (SLVERR). Hold until s_bready. Return to W_IDLE the cycle after the handshake.
  - Timing: AW handshake at cycle T gives s_wready = 1 from T+1. Last W beat at cycle U gives s_bvalid = 1 at U+1.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: s_arready = 1. On handshake, latch index, len and ok.
  - Read path: memory read is synchronous, followed by a one-entry output register with a skid buffer.
  - First beat: AR handshake at T gives s_rvalid = 1 at T+2.
  - Throughput: one beat per cycle while s_rready = 1. With s_rready = 0, s_rdata, s_rlast and s_rvalid hold stable and no beat is lost or duplicated.
  - s_rlast = 1 on beat len. s_rresp = 2'b00, or 2'b10 when ok = 0, in which case s_rdata = 0 and memory is not read.
  - After the s_rlast handshake, return to R_IDLE; s_arready = 1 on the next cycle.
- Concurrency: write and read bursts may overlap. If the same word is written and read in the same cycle, the read returns the old data (read-first).
- Zero-length case: len = 0 is a single beat. s_wlast on beat 0 is correct and raises no error.
- A new AW or AR is not accepted while the corresponding channel is busy; there is no outstanding-transaction queue.
- Reset mid-burst: both FSMs abort immediately and all valid/ready outputs go to 0. A partial write remains in memory.

Test Plan:
- Write 16-beat INCR at 0x1000_0000 with data 0..15, full strobe, then read back 16 beats with rready = 1 -> rdata 0..15, rlast only on beat 15, first rvalid 2 cycles after AR handshake, bresp = 0.
- Write at 0x1000_0008, wstrb = 8'h0F, wdata = 64'hAAAA_BBBB_CCCC_DDDD over prior 64'h1111_2222_3333_4444 -> read returns 64'h1111_2222_CCCC_DDDD.
- 256-beat read with rready toggling 1,0,0,1 pseudo-randomly -> exactly 256 beats, in order, no duplicates, with rdata stable whenever rvalid = 1 and rready = 0.
- AW at 0x1000_0000 + 8*(DEPTH_WORDS-4) with awlen = 7 -> bresp = 2'b10, memory unchanged, err_flags[2] = 1. Same burst on AR -> rresp = 2'b10 on all 8 beats, err_flags[3] = 1.
- awlen = 3 with wlast asserted on beat 1 -> response after 2 beats, err_flags[0] = 1. awlen = 3 with wlast never asserted -> response after 4 beats, err_flags[1] = 1.
- Overlapped 64-beat write to buffer A and 64-beat read from buffer B, followed by a read from A; assert rst mid-burst in a second run -> all outputs 0 within one cycle, FSMs idle, next AW/AR accepted normally.
